// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: latches the PC on a fetch request, runs the instruction-memory
// read handshake, loads IR and PC+1, and handles flush, timeout and a completed-fetch count.
module instr_fetch_unit #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned TIMEOUT   = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] pc_cur,
  input  logic                 fetch_start,
  input  logic                 flush,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_ready,
  output logic [WORD_SIZE-1:0] ir,
  output logic [WORD_SIZE-1:0] pc_plus1,
  output logic                 fetch_done,
  output logic                 fetch_err,
  output logic                 busy,
  output logic [WORD_SIZE-1:0] fetch_count
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax      = {CNT_W{1'b1}};

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     wait_cnt_q;
  logic [WORD_SIZE-1:0] addr_q, pc_plus1_q, ir_q, count_q;
  logic                 err_q, err_d;
  logic                 accept, timeout_hit, load_ir;

  // A new fetch is taken from IDLE or, back-to-back, from DONE.
  assign accept      = fetch_start && ((state_q == StIdle) || (state_q == StDone));
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == TimeoutLast);
  assign load_ir     = (state_q == StWait) && !flush && i_ready;

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: if (fetch_start) state_d = StWait;
      StWait: begin
        if (flush) begin
          state_d = StIdle;
        end else if (i_ready) begin
          state_d = StDone;
        end else if (timeout_hit) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      StDone:  state_d = fetch_start ? StWait : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      pc_plus1_q <= '0;
      ir_q       <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q     <= pc_cur;
        pc_plus1_q <= pc_cur + 1'b1;
        wait_cnt_q <= '0;
      end else if ((state_q == StWait) && (wait_cnt_q != CntMax)) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
      if (load_ir) begin
        ir_q    <= i_data;
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign i_readM     = (state_q == StWait);
  assign busy        = (state_q == StWait);
  assign fetch_done  = (state_q == StDone);
  assign fetch_err   = err_q;
  assign i_address   = addr_q;
  assign pc_plus1    = pc_plus1_q;
  assign ir          = ir_q;
  assign fetch_count = count_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage downstream of the program counter register in the multicycle CPU.
- Takes the current PC and a one-cycle fetch request from the control FSM, then runs a read handshake with instruction memory.
- Latches the returned word into the instruction register (IR) and presents PC+1 to the next-PC mux.
- Handles flush (abort) and memory timeout, and keeps a count of completed fetches.

Parameters:
WORD_SIZE, 16, width of address, data, IR and counters
TIMEOUT, 8, max cycles in WAIT before abort; 0 disables timeout
CNT_W, 4, width of internal wait counter (must hold TIMEOUT)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
pc_cur  input  WORD_SIZE  current PC from PC register
fetch_start  input  1  one-cycle fetch request from control FSM
flush  input  1  abort the in-flight fetch
i_readM  output  1  instruction memory read strobe
i_address  output  WORD_SIZE  instruction memory address
i_data  input  WORD_SIZE  instruction memory read data
i_ready  input  1  memory data-valid pulse
ir  output  WORD_SIZE  instruction register
pc_plus1  output  WORD_SIZE  latched fetch address + 1
fetch_done  output  1  one-cycle pulse: ir and pc_plus1 valid, PC may update
fetch_err  output  1  one-cycle pulse: timeout abort
busy  output  1  high while a fetch is outstanding
fetch_count  output  WORD_SIZE  number of completed fetches

Behaviour:
- Reset (async, active-high), any time including mid-fetch:
  - state=IDLE.
  - i_readM, i_address, ir, pc_plus1, fetch_done, fetch_err, busy, fetch_count and wait counter all 0.
  - No fetch_done or fetch_err emitted for the aborted fetch.
- All outputs are registered or decoded from the state register; there is no combinational path from inputs to outputs.
- States are IDLE, WAIT and DONE.
- IDLE:
  - fetch_start=1: latch i_address<=pc_cur, pc_plus1<=pc_cur+1 (mod 2^WORD_SIZE, so 0xFFFF -> 0x0000), clear wait counter, go to WAIT.
  - fetch_start=0: stay in IDLE.
  - i_ready in IDLE is ignored.
- WAIT:
  - i_readM=1, busy=1; i_address is held stable and unaffected by later pc_cur changes.
  - Wait counter increments every WAIT cycle, saturating.
  - Priority: flush > i_ready > timeout.
  - flush=1: go to IDLE; ir unchanged; no done or err pulse. This holds even if i_ready is 1 in the same cycle; that data is discarded.
  - i_ready=1: ir<=i_data, fetch_count<=fetch_count+1 (wraps), go to DONE.
  - TIMEOUT!=0 and counter==TIMEOUT-1 and no i_ready: go to IDLE with fetch_err=1 for one cycle.
  - fetch_start in WAIT is ignored.
- DONE:
  - fetch_done=1 for exactly one cycle; i_readM=0, busy=0.
  - fetch_start=1 is accepted exactly as in IDLE (back-to-back fetch, next state WAIT).
  - Otherwise go to IDLE.
  - flush in DONE has no effect; the fetch has already completed.
- Latency: fetch_start at cycle T gives i_readM=1 from T+1. i_ready at cycle T+k gives fetch_done at T+k+1, with ir valid from T+k+1 and held until the next successful fetch.
- i_readM deasserts on the cycle after i_ready, flush or timeout.
- fetch_err is never asserted together with fetch_done.

Test Plan:
- Reset, then pc_cur=0x0010, fetch_start pulse, i_ready with i_data=0xA5A5 after 3 cycles -> i_address=0x0010; i_readM high for 3 cycles; fetch_done pulse; ir=0xA5A5; pc_plus1=0x0011; fetch_count=1.
- pc_cur=0xFFFF (CPU reset value), fetch with i_ready after 1 cycle -> pc_plus1=0x0000; fetch_done pulse 2 cycles after fetch_start.
- Start fetch, then change pc_cur to 0x1234 during WAIT -> i_address holds the original value; ir loads i_data normally.
- flush and i_ready in the same WAIT cycle -> IDLE next cycle; no fetch_done; ir and fetch_count unchanged.
- TIMEOUT=8, never assert i_ready -> after 8 WAIT cycles fetch_err pulses once; i_readM low; busy low; fetch_count unchanged.
- fetch_start held high in DONE for 4 consecutive fetches, and separately reset asserted mid-WAIT -> back-to-back fetches give fetch_count=4; mid-WAIT reset immediately forces all outputs to 0 with no done/err pulse.
